// File: rtl/dff_pipe_en.sv
// Elastic enabled register pipeline with bubble collapse, stall, flush and valid/ready handshake.
// Optional occupancy count output is built when DFF_PIPE_OCC_EN is defined.
module dff_pipe_en #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            v_nxt;
  logic [DEPTH-1:0]            go;
  logic [DEPTH-1:0]            up_v;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0][WIDTH-1:0] data_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] up_d;

  // A stage may advance when it or any stage ahead of it has room to move.
  always_comb begin : go_chain
    logic g;
    g  = ~v[DEPTH-1] | out_ready;
    go = '0;
    go[DEPTH-1] = g;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      g     = ~v[k] | g;
      go[k] = g;
    end
  end

  // Upstream source for each stage: stage 0 sees the input port.
  always_comb begin
    up_v    = '0;
    up_d    = '0;
    up_v[0] = in_valid;
    up_d[0] = d;
    for (int k = 1; k < int'(DEPTH); k++) begin
      up_v[k] = v[k-1];
      up_d[k] = data[k-1];
    end
  end

  assign in_ready  = en & go[0] & ~clr;
  assign out_valid = v[DEPTH-1];
  assign q         = data[DEPTH-1];

  // Invalid loads clear the valid bit but leave the data register untouched.
  always_comb begin
    v_nxt    = v;
    data_nxt = data;
    if (clr) begin
      v_nxt    = '0;
      data_nxt = '0;
    end else if (en) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (go[k]) begin
          v_nxt[k] = up_v[k];
          if (up_v[k]) data_nxt[k] = up_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v    <= '0;
      data <= '0;
    end else begin
      v    <= v_nxt;
      data <= data_nxt;
    end
  end

`ifdef DFF_PIPE_OCC_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_nxt;

  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ_nxt = occ_nxt + OCC_W'(v_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occ <= '0;
    else          occ <= occ_nxt;
  end
`else
  // Occupancy is not tracked in this build.
`endif

endmodule

// File: tb/tb_dff_pipe_en.sv
// Self-checking bench for dff_pipe_en: position-based word model plus directed literal checks.
module tb_dff_pipe_en;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
`ifdef DFF_PIPE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  dff_pipe_en #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: words in flight, oldest first, each tagged with its stage position.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } word_t;

  word_t            mq[$];
  word_t            nq[$];
  word_t            w;
  logic [WIDTH-1:0] m_q = '0;
  bit   [DEPTH:0]   p_upd;
  bit   [DEPTH:0]   p_mon;

  // Bit i: word i advances (or leaves) this edge. Bit DEPTH: a new word can enter.
  function automatic bit [DEPTH:0] plan();
    bit [DEPTH:0] r = '0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].pos == DEPTH - 1) r[i] = out_ready;
      else r[i] = (i == 0) || (mq[i-1].pos != mq[i].pos + 1) || r[i-1];
    end
    r[DEPTH] = (mq.size() == 0) || (mq[mq.size()-1].pos != 0) || r[mq.size()-1];
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      m_q = '0;
    end else if (clr) begin
      mq.delete();
      m_q = '0;
    end else if (en) begin
      p_upd = plan();
      nq.delete();
      for (int i = 0; i < mq.size(); i++) begin
        w = mq[i];
        if (p_upd[i]) begin
          if (w.pos == DEPTH - 1) continue;
          w.pos++;
          if (w.pos == DEPTH - 1) m_q = w.data;
        end
        nq.push_back(w);
      end
      if (in_valid && p_upd[DEPTH]) begin
        w.data = d;
        w.pos  = 0;
        if (w.pos == DEPTH - 1) m_q = d;
        nq.push_back(w);
      end
      mq = nq;
    end
  end

  // Every-cycle compare of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    #3;
    if (mon_on) begin
      p_mon = plan();
      chk("mon_out_valid", 64'(out_valid), 64'((mq.size() > 0) && (mq[0].pos == DEPTH - 1)));
      chk("mon_q", 64'(q), 64'(m_q));
      chk("mon_in_ready", 64'(in_ready), 64'(en && !clr && p_mon[DEPTH]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic c, input logic iv, input logic [WIDTH-1:0] dd,
                     input logic orr);
    en        = e;
    clr       = c;
    in_valid  = iv;
    d         = dd;
    out_ready = orr;
  endtask

  initial begin
    reset_n = 1'b0;
    drv(0, 0, 0, '0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_q", 64'(q), 64'h0);
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // Stream: latency DEPTH, one word per cycle.
    drv(1, 0, 1, 8'h11, 1); tick;
    drv(1, 0, 1, 8'h22, 1); tick;
    drv(1, 0, 1, 8'h33, 1); tick;
    drv(1, 0, 0, 8'h00, 1);
    chk("stream_not_yet", 64'(out_valid), 64'h0);
    tick;
    chk("stream_ov", 64'(out_valid), 64'h1);
    chk("stream_q0", 64'(q), 64'h11);
    tick; chk("stream_q1", 64'(q), 64'h22);
    tick; chk("stream_q2", 64'(q), 64'h33);
    tick; chk("stream_done", 64'(out_valid), 64'h0);

    // Stall and bubble collapse.
    drv(1, 0, 1, 8'hA1, 0); tick;
    drv(1, 0, 0, 8'h00, 0); tick;
    drv(1, 0, 1, 8'hA2, 0); tick;
    drv(1, 0, 1, 8'hB3, 0); tick;
    drv(1, 0, 1, 8'hB4, 0); tick;
    drv(1, 0, 1, 8'hC5, 0); #1;
    chk("full_in_ready", 64'(in_ready), 64'h0);
    chk("full_ov", 64'(out_valid), 64'h1);
    chk("full_q", 64'(q), 64'hA1);
    tick;
    drv(1, 0, 0, 8'h00, 1);
    tick; chk("drain_q1", 64'(q), 64'hA2);
    tick; chk("drain_q2", 64'(q), 64'hB3);
    tick; chk("drain_q3", 64'(q), 64'hB4);
    tick; chk("drain_empty", 64'(out_valid), 64'h0);

    // Enable low freezes everything mid-flight.
    drv(1, 0, 1, 8'h5A, 1); tick;
    drv(1, 0, 0, 8'h00, 1); tick;
    drv(0, 0, 1, 8'hEE, 1); #1;
    chk("en0_in_ready", 64'(in_ready), 64'h0);
    repeat (3) tick;
    chk("en0_ov", 64'(out_valid), 64'h0);
    chk("en0_q_hold", 64'(q), 64'hB4);
    drv(1, 0, 0, 8'h00, 1);
    tick; chk("en1_not_yet", 64'(out_valid), 64'h0);
    tick; chk("en1_ov", 64'(out_valid), 64'h1);
    chk("en1_q", 64'(q), 64'h5A);
    tick;

    // Flush a full pipe while offering a word.
    drv(1, 0, 1, 8'h01, 0); tick;
    drv(1, 0, 1, 8'h02, 0); tick;
    drv(1, 0, 1, 8'h03, 0); tick;
    drv(1, 0, 1, 8'h04, 0); tick;
    drv(1, 0, 0, 8'h00, 0);
    chk("prefl_q", 64'(q), 64'h01);
    drv(1, 1, 1, 8'hFF, 0); #1;
    chk("clr_in_ready", 64'(in_ready), 64'h0);
    tick;
    drv(1, 0, 0, 8'h00, 1);
    chk("clr_ov", 64'(out_valid), 64'h0);
    chk("clr_q", 64'(q), 64'h0);
    repeat (5) tick;
    chk("clr_ff_dropped", 64'(out_valid), 64'h0);

    // Async reset between edges with two words in flight.
    drv(1, 0, 1, 8'h31, 1); tick;
    drv(1, 0, 1, 8'h32, 1); tick;
    drv(1, 0, 0, 8'h00, 1); tick; tick;
    chk("prerst_q", 64'(q), 64'h31);
    reset_n = 1'b0;
    #1;
    chk("arst_ov", 64'(out_valid), 64'h0);
    chk("arst_q", 64'(q), 64'h0);
    reset_n = 1'b1;
    drv(1, 0, 1, 8'h44, 1); tick;
    drv(1, 0, 0, 8'h00, 1); tick; tick;
    chk("arst_lat_early", 64'(out_valid), 64'h0);
    tick;
    chk("arst_lat_ov", 64'(out_valid), 64'h1);
    chk("arst_lat_q", 64'(q), 64'h44);
    tick;
    chk("arst_no_32", 64'(out_valid), 64'h0);

    // Full pipe: simultaneous pop and push.
    drv(1, 0, 1, 8'h61, 0); tick;
    drv(1, 0, 1, 8'h62, 0); tick;
    drv(1, 0, 1, 8'h63, 0); tick;
    drv(1, 0, 1, 8'h64, 0); tick;
    drv(1, 0, 1, 8'h77, 1); #1;
    chk("pass_in_ready", 64'(in_ready), 64'h1);
    tick;
    drv(1, 0, 0, 8'h00, 1);
    chk("pass_q1", 64'(q), 64'h62);
    tick; chk("pass_q2", 64'(q), 64'h63);
    tick; chk("pass_q3", 64'(q), 64'h64);
    tick; chk("pass_q77", 64'(q), 64'h77);
    tick;

    // Mixed enable / valid / ready pattern, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      drv(logic'(i % 7 != 3), logic'(i == 45), logic'(i % 3 != 2), WIDTH'(i * 13 + 5),
          logic'(i % 4 != 0));
      tick;
    end
    drv(1, 0, 0, 8'h00, 1);
    repeat (6) tick;
    chk("final_empty", 64'(out_valid), 64'h0);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_pipe_en.md
DFF_PIPE_EN -- requirements
Module: dff_pipe_en

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per stage (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning register stages (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1, meaning single rising-edge clock for all state.
REQ-004 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, meaning global enable; 0 freezes all state (stall).
REQ-006 The block SHALL have port clr, input, 1, meaning synchronous flush of all stages.
REQ-007 The block SHALL have port in_valid, input, 1, meaning d carries a word.
REQ-008 The block SHALL have port in_ready, output, 1, meaning a word is accepted this cycle when in_valid is also 1.
REQ-009 The block SHALL have port d, input, WIDTH, meaning input data.
REQ-010 The block SHALL have port out_valid, output, 1, meaning q carries a word.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes q this cycle.
REQ-012 The block SHALL have port q, output, WIDTH, meaning the last stage data register, driven regardless of out_valid.

Function
REQ-013 Each stage k (0 = input side, DEPTH-1 = output) SHALL hold one data register and one valid bit v[k].
REQ-014 Define go[DEPTH-1] = !v[DEPTH-1] | out_ready and go[k] = !v[k] | go[k+1]; stage k SHALL load from its upstream neighbour (stage 0 from {in_valid,d}) on a clock edge iff en=1 and go[k]=1.
REQ-015 Bubbles SHALL collapse: an empty stage loads even when downstream is stalled.
REQ-016 in_ready SHALL equal en & go[0] & !clr; it is a combinational path from out_ready and en.
REQ-017 out_valid SHALL equal v[DEPTH-1]; q SHALL equal the stage DEPTH-1 data register.
REQ-018 A stage that loads from an invalid upstream SHALL take v=0 and SHALL keep its data register unchanged.
REQ-019 Latency SHALL be exactly DEPTH cycles from acceptance to out_valid in an empty, unstalled pipe; throughput SHALL be one word per cycle with out_ready held 1.
REQ-020 Words SHALL emerge in acceptance order, none dropped or duplicated.
REQ-021 With en=0, no register SHALL change, in_ready SHALL be 0, and out_valid and q SHALL hold.
REQ-022 clr=1 at a clock edge SHALL clear every v[k] and data register to 0, override en and all handshakes, and accept no input that cycle.
REQ-023 When full (all v=1) with out_ready=0, in_ready SHALL be 0; if out_ready=1, in_ready SHALL be 1 (pass-through under simultaneous pop and push).
REQ-024 With DEPTH=1, the block SHALL behave as a single enabled register with handshake, in_ready = en & (!v[0] | out_ready) & !clr.

Reset
REQ-025 reset_n low SHALL immediately, without a clock, set all v[k]=0, all data registers=0, out_valid=0, q=0, and occ=0 when present.
REQ-026 Reset asserted mid-transfer SHALL discard all words in flight; the first edge after release SHALL behave as for an empty pipe.

Configuration
REQ-027 With macro DFF_PIPE_OCC_EN defined, the block SHALL add output occ, width $clog2(DEPTH+1), registered, equal to the count of v[k]=1 after each edge.
REQ-028 Without DFF_PIPE_OCC_EN, port occ SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Stream test, WIDTH=8, DEPTH=4, en=1, out_ready=1: push 0x11,0x22,0x33 on consecutive cycles -> out_valid rises 4 cycles after the first push, q=0x11,0x22,0x33 on consecutive cycles.
REQ-030 Stall and collapse test: push 0xA1,bubble,0xA2 with out_ready=0 -> the pipe compacts with no gap, in_ready=0 once 4 words are held, and the words drain in order when out_ready=1.
REQ-031 Enable test: pipe holds 0x5A mid-flight, en=0 for 3 cycles -> all state frozen and in_ready=0; after en=1, 0x5A appears at q after the remaining stages.
REQ-032 Flush test: pipe full, clr=1 with in_valid=1, d=0xFF -> next cycle out_valid=0, q=0x00, occ=0, and 0xFF not accepted.
REQ-033 Async reset test: reset_n pulsed low between clock edges while 2 words are in flight -> out_valid=0 and q=0 before the next edge, and the next push has latency 4.
REQ-034 Full pass-through test: pipe full, out_ready=1, in_valid=1, d=0x77 -> in_ready=1, occ stays 4, and 0x77 exits 4 cycles later.
